// File: rtl/u_lsu.sv
// u_lsu -- RV32I load/store unit sitting directly downstream of u_exe.
// Takes one memory op per ex_valid/ex_ready handshake and drives a
// req/gnt/rvalid data-memory port. Store data is lane-replicated and load data
// is extracted and sign/zero-extended for a 1-cycle register-file writeback.
// Illegal funct3 and timed-out accesses pulse lsu_err and latch the op address.
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses (no bus access, error pulse). Without it the low address bits are
// forced down to size alignment and the access proceeds normally.
module u_lsu #(
   parameter int unsigned TO_CYC = 255,  // req->rvalid cycle budget, 0 = no timeout
   parameter int unsigned CW     = 8     // timeout counter width, TO_CYC < 2**CW
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_ld,
   input  logic        ex_st,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic [4:0]  ex_rd_a,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        rf_rd_e,
   output logic [4:0]  rf_rd_a,
   output logic [31:0] rf_rd_i,
   output logic        lsu_err,
   output logic [31:0] lsu_err_addr
);

   localparam logic [CW-1:0] TO_LIM = CW'(TO_CYC);
   localparam bit            TO_EN  = (TO_CYC != 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   state_e        state_q,      state_d;
   logic [CW-1:0] cnt_q,        cnt_d;
   logic          we_q,         we_d;
   logic [31:0]   addr_q,       addr_d;      // raw address of the op in flight
   logic [1:0]    lane_q,       lane_d;      // aligned byte lane used for extract
   logic [3:0]    be_q,         be_d;
   logic [31:0]   wdata_q,      wdata_d;
   logic [2:0]    f3_q,         f3_d;
   logic [4:0]    rd_q,         rd_d;
   logic          rf_rd_e_q,    rf_rd_e_d;
   logic [4:0]    rf_rd_a_q,    rf_rd_a_d;
   logic [31:0]   rf_rd_i_q,    rf_rd_i_d;
   logic          err_q,        err_d;
   logic [31:0]   err_addr_q,   err_addr_d;

   logic          accept;
   logic          f3_legal;
   logic          go_bus;
   logic [1:0]    lane_c;
   logic [3:0]    be_c;
   logic [31:0]   wdata_c;
`ifdef MISALIGN_TRAP_EN
   logic          misalign;
`endif

   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_data;
   logic          to_hit;

   // Decode the op offered by u_exe: legality, byte lane, enables, store data.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through
      // the case statements can leave one unassigned and infer a latch.
      accept  = (state_q == S_IDLE) && ex_valid && (ex_ld || ex_st);
      lane_c  = 2'b00;
      be_c    = 4'hF;
      wdata_c = ex_wdata;

      // A load wins when both ex_ld and ex_st are set.
      if (ex_ld) begin
         f3_legal = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end else begin
         f3_legal = ex_funct3 inside {3'b000, 3'b001, 3'b010};
      end

      unique case (ex_funct3[1:0])
         2'b00: begin
            lane_c  = ex_addr[1:0];
            be_c    = 4'b0001 << ex_addr[1:0];
            wdata_c = {4{ex_wdata[7:0]}};
         end
         2'b01: begin
            // Halfword lane is forced even; with the trap enabled an odd
            // address never reaches the bus anyway.
            lane_c  = {ex_addr[1], 1'b0};
            be_c    = 4'b0011 << {ex_addr[1], 1'b0};
            wdata_c = {2{ex_wdata[15:0]}};
         end
         default: ;
      endcase

`ifdef MISALIGN_TRAP_EN
      misalign = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                 ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
      go_bus   = f3_legal && !misalign;
`else
      go_bus   = f3_legal;
`endif
   end

   // Pick the addressed byte/halfword out of the response word and extend it.
   always_comb begin
      ld_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
      ld_half = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
      unique case (f3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = dmem_rdata;
      endcase
   end

   // The counter would reach the limit on this edge.
   assign to_hit = TO_EN && ((cnt_q + CW'(1)) == TO_LIM);

   // Next-state logic: IDLE -> REQ (until gnt) -> WAIT (until rvalid) -> IDLE.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      lane_d     = lane_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      f3_d       = f3_q;
      rd_d       = rd_q;
      rf_rd_e_d  = 1'b0;
      rf_rd_a_d  = rf_rd_a_q;
      rf_rd_i_d  = rf_rd_i_q;
      err_d      = 1'b0;
      err_addr_d = err_addr_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d = '0;
               if (go_bus) begin
                  state_d = S_REQ;
                  we_d    = !ex_ld;
                  addr_d  = ex_addr;
                  lane_d  = lane_c;
                  be_d    = be_c;
                  wdata_d = wdata_c;
                  f3_d    = ex_funct3;
                  rd_d    = ex_rd_a;
               end else begin
                  // Rejected op is consumed without touching the bus.
                  err_d      = 1'b1;
                  err_addr_d = ex_addr;
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + CW'(1);
            if (to_hit) begin
               state_d    = S_IDLE;
               err_d      = 1'b1;
               err_addr_d = addr_q;
            end else if (dmem_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // A response arriving on the last allowed cycle still completes.
            if (dmem_rvalid) begin
               state_d = S_IDLE;
               if (!we_q && (rd_q != 5'd0)) begin
                  rf_rd_e_d = 1'b1;
                  rf_rd_a_d = rd_q;
                  rf_rd_i_d = ld_data;
               end
            end else if (to_hit) begin
               state_d    = S_IDLE;
               err_d      = 1'b1;
               err_addr_d = addr_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         lane_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         f3_q       <= '0;
         rd_q       <= '0;
         rf_rd_e_q  <= 1'b0;
         rf_rd_a_q  <= '0;
         rf_rd_i_q  <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         lane_q     <= lane_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         f3_q       <= f3_d;
         rd_q       <= rd_d;
         rf_rd_e_q  <= rf_rd_e_d;
         rf_rd_a_q  <= rf_rd_a_d;
         rf_rd_i_q  <= rf_rd_i_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign ex_ready     = (state_q == S_IDLE) && !rst;
   assign dmem_req     = (state_q == S_REQ);
   assign dmem_we      = we_q;
   assign dmem_addr    = {addr_q[31:2], 2'b00};
   assign dmem_be      = be_q;
   assign dmem_wdata   = wdata_q;
   assign rf_rd_e      = rf_rd_e_q;
   assign rf_rd_a      = rf_rd_a_q;
   assign rf_rd_i      = rf_rd_i_q;
   assign lsu_err      = err_q;
   assign lsu_err_addr = err_addr_q;

endmodule

// File: tb/tb_u_lsu.sv
// tb_u_lsu -- self-checking bench for u_lsu. A transaction-level model derives
// the expected port values from the unit's rules (size, lane, extension,
// timeout budget); a negedge compare process checks them every cycle.
module tb_u_lsu;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready, ex_ld, ex_st;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr, ex_wdata;
   logic [4:0]  ex_rd_a;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        rf_rd_e, lsu_err;
   logic [4:0]  rf_rd_a;
   logic [31:0] rf_rd_i, lsu_err_addr;

   always #5 clk = ~clk;

   u_lsu #(.TO_CYC(TO), .CW(8)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ld(ex_ld), .ex_st(ex_st),
      .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd_a(ex_rd_a),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .rf_rd_e(rf_rd_e), .rf_rd_a(rf_rd_a), .rf_rd_i(rf_rd_i),
      .lsu_err(lsu_err), .lsu_err_addr(lsu_err_addr)
   );

   int n_vec  = 0;
   int n_miss = 0;
   bit chk_en = 1'b0;

   // Expected values for the current cycle, maintained by the model.
   logic        exp_ready, exp_req, exp_we, exp_rde, exp_err;
   logic [31:0] exp_addr, exp_wdata, exp_rdi, exp_err_addr;
   logic [3:0]  exp_be;
   logic [4:0]  exp_rda;

   // Observations gathered by the compare process (monotonic counters + last seen).
   int          req_cycles = 0, wb_pulses = 0, err_pulses = 0;
   logic [31:0] last_addr = '0, last_wdata = '0, last_rdi = '0;
   logic [3:0]  last_be = '0;
   logic        last_we = 1'b0;
   logic [4:0]  last_rda = '0;

   logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int size_b(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit is_legal(input bit ld, input logic [2:0] f3);
      if (ld) return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      return f3 inside {3'b000, 3'b001, 3'b010};
   endfunction

   function automatic bit misaligned(input logic [31:0] a, input logic [2:0] f3);
      return (a % 32'(size_b(f3))) != 0;
   endfunction

   function automatic logic [31:0] align_down(input logic [31:0] a, input logic [2:0] f3);
      return a - (a % 32'(size_b(f3)));
   endfunction

   function automatic logic [3:0] be_of(input logic [31:0] ea, input logic [2:0] f3);
      return 4'(((1 << size_b(f3)) - 1) << ea[1:0]);
   endfunction

   function automatic logic [31:0] rep(input logic [31:0] wd, input logic [2:0] f3);
      logic [31:0] r;
      int sz;
      sz = size_b(f3);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ext(input logic [31:0] rd, input logic [31:0] ea,
                                        input logic [2:0] f3);
      logic [31:0] v, m;
      int sz;
      sz = size_b(f3);
      v  = rd >> (8 * int'(ea[1:0]));
      if (sz == 4) return v;
      m = (32'h1 << (8 * sz)) - 32'h1;
      v = v & m;
      if (!f3[2] && v[8*sz-1]) v = v | ~m;
      return v;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("ex_ready", ex_ready, exp_ready);
         check("dmem_req", dmem_req, exp_req);
         if (exp_req) begin
            check("dmem_addr", dmem_addr, exp_addr);
            check("dmem_be", dmem_be, exp_be);
            check("dmem_we", dmem_we, exp_we);
            if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
         end
         check("rf_rd_e", rf_rd_e, exp_rde);
         if (exp_rde) begin
            check("rf_rd_a", rf_rd_a, exp_rda);
            check("rf_rd_i", rf_rd_i, exp_rdi);
         end
         check("lsu_err", lsu_err, exp_err);
         check("lsu_err_addr", lsu_err_addr, exp_err_addr);
         if (dmem_req) begin
            req_cycles++;
            last_addr  = dmem_addr;
            last_be    = dmem_be;
            last_we    = dmem_we;
            last_wdata = dmem_wdata;
         end
         if (rf_rd_e) begin
            wb_pulses++;
            last_rdi = rf_rd_i;
            last_rda = rf_rd_a;
         end
         if (lsu_err) err_pulses++;
      end
   end

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
      exp_rde = 1'b0;
      exp_err = 1'b0;
   endtask

   // mode 0: quiet bus, 1: random gnt/rvalid noise, 2: rvalid held high
   task automatic idle(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         ex_valid    = (mode == 1) ? 1'($urandom) : 1'b0;
         ex_ld       = 1'b0;
         ex_st       = 1'b0;
         dmem_gnt    = (mode == 1) ? 1'($urandom) : 1'b0;
         dmem_rvalid = (mode == 2) ? 1'b1 : ((mode == 1) ? 1'($urandom) : 1'b0);
         dmem_rdata  = $urandom;
         step();
      end
      ex_valid    = 1'b0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
   endtask

   // One op: gnt after gnt_dly REQ cycles, rvalid after rv_dly WAIT cycles.
   // lat returns the edge (counted from accept) that ended the op.
   task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                        input bit noise, output int lat);
      bit          go, in_wait, g_now, r_now;
      int          wait_cnt;
      logic [31:0] ea;
      lat       = 0;
      ex_valid  = 1'b1;
      ex_ld     = ld;
      ex_st     = st;
      ex_funct3 = f3;
      ex_addr   = a;
      ex_wdata  = wd;
      ex_rd_a   = rd;
      step();
      ex_valid  = 1'b0;
      if (!ld && !st) return;
      go = is_legal(ld, f3);
`ifdef MISALIGN_TRAP_EN
      if (go && misaligned(a, f3)) go = 1'b0;
`endif
      if (!go) begin
         exp_err      = 1'b1;
         exp_err_addr = a;
         return;
      end
      ea        = align_down(a, f3);
      exp_ready = 1'b0;
      exp_req   = 1'b1;
      exp_addr  = {ea[31:2], 2'b00};
      exp_be    = be_of(ea, f3);
      exp_we    = !ld;
      exp_wdata = rep(wd, f3);
      in_wait   = 1'b0;
      wait_cnt  = 0;
      for (int k = 1; k <= 64; k++) begin
         g_now       = in_wait ? (noise && 1'($urandom)) : (k - 1 == gnt_dly);
         r_now       = in_wait ? (wait_cnt == rv_dly) : (noise && 1'($urandom));
         dmem_gnt    = g_now;
         dmem_rvalid = r_now;
         dmem_rdata  = (in_wait && r_now) ? rdata : $urandom;
         step();
         if (in_wait && r_now) begin
            exp_req   = 1'b0;
            exp_ready = 1'b1;
            if (ld && rd != 5'd0) begin
               exp_rde = 1'b1;
               exp_rda = rd;
               exp_rdi = ext(rdata, ea, f3);
            end
            lat = k;
         end else if (TO != 0 && k == TO) begin
            exp_req      = 1'b0;
            exp_ready    = 1'b1;
            exp_err      = 1'b1;
            exp_err_addr = a;
            lat = k;
         end else if (!in_wait && g_now) begin
            in_wait = 1'b1;
            exp_req = 1'b0;
         end else if (in_wait) begin
            wait_cnt++;
         end
         if (lat != 0) break;
      end
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (lat == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL op_bound: op never completed, got busy expected done at %0t", $time);
      end
   endtask

   // Synchronous reset while a load is in REQ or WAIT, then a stray rvalid.
   task automatic rst_mid(input bit in_wait);
      int b_wb;
      b_wb      = wb_pulses;
      ex_valid  = 1'b1;
      ex_ld     = 1'b1;
      ex_st     = 1'b0;
      ex_funct3 = 3'b010;
      ex_addr   = 32'h400;
      ex_rd_a   = 5'd3;
      step();
      ex_valid  = 1'b0;
      exp_ready = 1'b0;
      exp_req   = 1'b1;
      exp_addr  = 32'h400;
      exp_be    = 4'hF;
      exp_we    = 1'b0;
      if (in_wait) begin
         dmem_gnt = 1'b1;
         step();
         dmem_gnt = 1'b0;
         exp_req  = 1'b0;
      end
      rst       = 1'b1;
      exp_ready = 1'b0;
      step();
      exp_req      = 1'b0;
      exp_err_addr = 32'h0;
      check("rst_mid_rf_rd_i", rf_rd_i, 32'h0);
      check("rst_mid_dmem_be", dmem_be, 32'h0);
      rst       = 1'b0;
      exp_ready = 1'b1;
      idle(2, 2);
      idle(1, 0);
      check("rst_mid_no_wb", wb_pulses - b_wb, 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int lat, b_req, b_wb, b_err;
      rst = 1'b1;
      ex_valid = 1'b0; ex_ld = 1'b0; ex_st = 1'b0; ex_funct3 = '0;
      ex_addr = '0; ex_wdata = '0; ex_rd_a = '0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      exp_ready = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_rde = 1'b0; exp_err = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_rdi = '0; exp_err_addr = '0; exp_be = '0; exp_rda = '0;

      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("rst_dmem_addr", dmem_addr, 32'h0);
      check("rst_dmem_be", dmem_be, 32'h0);
      check("rst_dmem_wdata", dmem_wdata, 32'h0);
      check("rst_dmem_we", dmem_we, 32'h0);
      check("rst_rf_rd_a", rf_rd_a, 32'h0);
      check("rst_rf_rd_i", rf_rd_i, 32'h0);
      step();
      rst       = 1'b0;
      exp_ready = 1'b1;
      idle(2, 0);

      // SW, immediate gnt/rvalid; done on edge T+2, next accept possible at T+3.
      b_wb = wb_pulses;
      do_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0, 1'b0, lat);
      idle(1, 0);
      check("t1_addr", last_addr, 32'h100);
      check("t1_be", last_be, 32'hF);
      check("t1_we", last_we, 32'h1);
      check("t1_wdata", last_wdata, 32'hDEADBEEF);
      check("t1_no_wb", wb_pulses - b_wb, 32'd0);
      check("t1_done_edge", lat, 32'd2);

      // LB / LBU at lane 3.
      do_op(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 5'd5, 0, 0, 32'h80112233, 1'b0, lat);
      idle(1, 0);
      check("t2_lb_data", last_rdi, 32'hFFFFFF80);
      check("t2_lb_rd", last_rda, 32'd5);
      do_op(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 5'd6, 0, 0, 32'h80112233, 1'b0, lat);
      idle(1, 0);
      check("t2_lbu_data", last_rdi, 32'h00000080);

      // SH / LH at lane 2.
      do_op(1'b0, 1'b1, 3'b001, 32'h42, 32'h0000ABCD, 5'd0, 0, 0, 32'h0, 1'b0, lat);
      idle(1, 0);
      check("t3_sh_be", last_be, 32'hC);
      check("t3_sh_wdata", last_wdata, 32'hABCDABCD);
      do_op(1'b1, 1'b0, 3'b001, 32'h42, 32'h0, 5'd7, 0, 0, 32'h7FFF0000, 1'b0, lat);
      idle(1, 0);
      check("t3_lh_data", last_rdi, 32'h00007FFF);

      // Delayed gnt: request held for five cycles.
      b_req = req_cycles;
      do_op(1'b0, 1'b1, 3'b000, 32'h3, 32'h5A, 5'd0, 4, 1, 32'h0, 1'b0, lat);
      idle(1, 0);
      check("t4_req_cycles", req_cycles - b_req, 32'd5);
      check("t4_sb_be", last_be, 32'h8);

      // Timeout: no rvalid, error on edge TO, late rvalid ignored.
      b_wb = wb_pulses; b_err = err_pulses;
      do_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd8, 1, 100, 32'h0, 1'b0, lat);
      check("t4_timeout_edge", lat, 32'd8);
      idle(3, 2);
      idle(1, 0);
      check("t4_timeout_err", err_pulses - b_err, 32'd1);
      check("t4_timeout_addr", lsu_err_addr, 32'h300);
      check("t4_timeout_no_wb", wb_pulses - b_wb, 32'd0);

      // Misaligned LW.
      b_req = req_cycles; b_err = err_pulses;
      do_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd10, 0, 0, 32'h12345678, 1'b0, lat);
      idle(1, 0);
`ifdef MISALIGN_TRAP_EN
      check("t5_mis_err", err_pulses - b_err, 32'd1);
      check("t5_mis_noreq", req_cycles - b_req, 32'd0);
      check("t5_mis_addr", lsu_err_addr, 32'h101);
`else
      check("t5_mis_addr", last_addr, 32'h100);
      check("t5_mis_data", last_rdi, 32'h12345678);
      check("t5_mis_noerr", err_pulses - b_err, 32'd0);
`endif

      // Reset mid-op, then illegal funct3 ops.
      rst_mid(1'b1);
      check("t6_err_addr_clr", lsu_err_addr, 32'h0);
      rst_mid(1'b0);
      b_req = req_cycles; b_err = err_pulses;
      do_op(1'b1, 1'b0, 3'b011, 32'h44, 32'h0, 5'd4, 0, 0, 32'h0, 1'b0, lat);
      do_op(1'b0, 1'b1, 3'b110, 32'h48, 32'h1, 5'd0, 0, 0, 32'h0, 1'b0, lat);
      idle(1, 0);
      check("t6_illegal_err", err_pulses - b_err, 32'd2);
      check("t6_illegal_noreq", req_cycles - b_req, 32'd0);
      check("t6_illegal_addr", lsu_err_addr, 32'h48);

      // ld&st together is a load; rd=0 load writes nothing back.
      do_op(1'b1, 1'b1, 3'b100, 32'h51, 32'hFFFFFFFF, 5'd9, 0, 0, 32'h0000C300, 1'b0, lat);
      idle(1, 0);
      check("both_is_load_we", last_we, 32'h0);
      check("both_is_load_data", last_rdi, 32'h000000C3);
      b_wb = wb_pulses;
      do_op(1'b1, 1'b0, 3'b010, 32'h60, 32'h0, 5'd0, 0, 0, 32'h11111111, 1'b0, lat);
      idle(1, 0);
      check("rd0_no_wb", wb_pulses - b_wb, 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         bit          ld, st;
         logic [2:0]  f3;
         int          sel, g, r;
         sel = $urandom_range(0, 9);
         ld  = (sel < 5) || (sel == 9 && 1'($urandom));
         st  = (sel >= 5 && sel < 9) || (sel == 9 && 1'($urandom));
         if ($urandom_range(0, 9) < 8)
            f3 = st && !ld ? legal_f3[$urandom_range(0, 2)] : legal_f3[$urandom_range(0, 4)];
         else
            f3 = 3'($urandom);
         g = $urandom_range(0, 3);
         r = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 8) : $urandom_range(0, 2);
         do_op(ld, st, f3, $urandom, $urandom, 5'($urandom), g, r, $urandom,
               1'($urandom), lat);
         idle($urandom_range(0, 2), 1);
      end

      idle(2, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

endmodule
